// File: rtl/key_irq_pio_pkg.sv
// ============================================================================
// Module      : key_irq_pio_pkg
// Description : Shared register addresses and edge-mode encoding for key_irq_pio.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_irq_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_mode_e;

endpackage

`default_nettype wire

// File: rtl/pio_debounce.sv
// ============================================================================
// Module      : pio_debounce
// Description : One input channel: 2-flop synchroniser plus optional debounce
//               counter (built only when KEY_IRQ_PIO_DEBOUNCE_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pio_debounce
  import key_irq_pio_pkg::*;
#(
  parameter int   DB_CYCLES  = 500000,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef KEY_IRQ_PIO_DEBOUNCE_EN
  localparam int              CNT_W    = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             stable_q;
  logic             stable_d;

  // Any return to the stable level restarts the stability window.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= IDLE_LEVEL;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
`else
  assign stable_o = sync2_q;
`endif

endmodule

`default_nettype wire

// File: rtl/key_irq_pio.sv
// ============================================================================
// Module      : key_irq_pio
// Description : N-channel interrupt-capable parallel input port with Avalon-MM
//               slave registers. Debounce enabled by KEY_IRQ_PIO_DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_irq_pio
  import key_irq_pio_pkg::*;
#(
  parameter int   WIDTH      = 4,
  parameter int   EDGE_MODE  = 1,
  parameter int   DB_CYCLES  = 500000,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam edge_mode_e MODE = edge_mode_e'(EDGE_MODE[1:0]);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_dly_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] edge_capture_q;
  logic [WIDTH-1:0] edge_capture_d;
  logic [WIDTH-1:0] irq_mask_q;
  logic [WIDTH-1:0] irq_mask_d;
  logic [31:0]      rd_mux;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;
  logic             irq_q;
  logic             irq_d;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    pio_debounce #(
      .DB_CYCLES  (DB_CYCLES),
      .IDLE_LEVEL (IDLE_LEVEL)
    ) u_db (
      .clk      (clk),
      .reset    (reset),
      .raw_i    (in_port[i]),
      .stable_o (stable[i])
    );
  end

  assign rise = stable & ~stable_dly_q;
  assign fall = ~stable & stable_dly_q;

  always_comb begin
    edge_hit = '0;
    case (MODE)
      EDGE_RISE: edge_hit = rise;
      EDGE_FALL: edge_hit = fall;
      default:   edge_hit = rise | fall;
    endcase
  end

  // New edges are OR-ed in after the clear so a same-cycle edge survives.
  always_comb begin
    edge_clr       = (write && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    edge_capture_d = (edge_capture_q & ~edge_clr) | edge_hit;
    irq_mask_d     = (write && address == ADDR_MASK) ? writedata[WIDTH-1:0] : irq_mask_q;
    irq_d          = |(edge_capture_q & irq_mask_q);
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = stable;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_capture_q;
      default:   rd_mux = '0;
    endcase
    readdata_d = read ? rd_mux : readdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_dly_q   <= {WIDTH{IDLE_LEVEL}};
      edge_capture_q <= '0;
      irq_mask_q     <= '0;
      readdata_q     <= '0;
      irq_q          <= 1'b0;
    end else begin
      stable_dly_q   <= stable;
      edge_capture_q <= edge_capture_d;
      irq_mask_q     <= irq_mask_d;
      readdata_q     <= readdata_d;
      irq_q          <= irq_d;
    end
  end

  assign readdata     = readdata_q;
  assign irq          = irq_q;
  assign unused_wdata = ^writedata;

endmodule

`default_nettype wire

// File: tb/tb_key_irq_pio.sv
// ============================================================================
// Module      : tb_key_irq_pio
// Description : Directed self-checking bench for key_irq_pio (WIDTH=4,
//               DB_CYCLES=4, falling edge); timing follows KEY_IRQ_PIO_DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_irq_pio;
  import key_irq_pio_pkg::*;

  localparam int W  = 4;
  localparam int DB = 4;
`ifdef KEY_IRQ_PIO_DEBOUNCE_EN
  localparam int LAT = 2 + DB + 1;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  in_port;
  logic [1:0]    address;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          irq;
  logic [31:0]   rd;
  int            n_vec = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  key_irq_pio #(
    .WIDTH      (W),
    .EDGE_MODE  (1),
    .DB_CYCLES  (DB),
    .IDLE_LEVEL (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_port   (in_port),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq)
  );

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    tick();
    read    = 1'b0;
    d       = readdata;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    tick();
    write     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_port = 4'hF; address = 2'd0;
    read = 1'b0; write = 1'b0; writedata = 32'h0;

    // Reset state
    tick(20);
    chk("rst_readdata", readdata, 32'h0);
    reset = 1'b0;
    tick();
    chk("rst_edge", 32'(dut.edge_capture_q), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    bus_rd(ADDR_DATA, rd);
    chk("rst_data", rd, 32'h0000_000F);

    // Bit-0 falling edge, masked in
    bus_wr(ADDR_MASK, 32'h1);
    in_port = 4'hE;
    tick(LAT - 1);
    chk("b0_edge_early", 32'(dut.edge_capture_q), 32'h0);
    tick();
    chk("b0_edge_set", 32'(dut.edge_capture_q), 32'h1);
    chk("b0_irq_lag", 32'(irq), 32'h0);
    tick();
    chk("b0_irq_set", 32'(irq), 32'h1);
    tick(10 - LAT - 1);
    in_port = 4'hF;
    tick(LAT + 2);
    bus_rd(ADDR_EDGE, rd);
    chk("b0_rd_edge", rd, 32'h1);

    // Short glitch on bit 1
    in_port = 4'hD;
    tick(3);
    in_port = 4'hF;
`ifdef KEY_IRQ_PIO_DEBOUNCE_EN
    for (int k = 0; k < 6; k++) begin
      bus_rd(ADDR_DATA, rd);
      chk("glitch_data", rd, 32'h0000_000F);
    end
    chk("glitch_edge", 32'(dut.edge_capture_q), 32'h1);
`else
    tick(LAT + 2);
    chk("glitch_edge", 32'(dut.edge_capture_q), 32'h3);
    bus_wr(ADDR_EDGE, 32'h2);
`endif
    bus_rd(ADDR_DATA, rd);
    chk("glitch_data_end", rd, 32'h0000_000F);

    // Clear with coincident read of the edge register
    address = ADDR_EDGE; writedata = 32'h1; write = 1'b1; read = 1'b1;
    tick();
    write = 1'b0; read = 1'b0;
    chk("clr_rd_preclear", readdata, 32'h1);
    chk("clr_edge", 32'(dut.edge_capture_q), 32'h0);
    chk("clr_irq_lag", 32'(irq), 32'h1);
    tick();
    chk("clr_irq_low", 32'(irq), 32'h0);

    // New edge landing on the same cycle as a clear
    in_port = 4'hE;
    tick(LAT - 1);
    address = ADDR_EDGE; writedata = 32'h1; write = 1'b1;
    tick();
    write = 1'b0;
    chk("coll_edge", 32'(dut.edge_capture_q), 32'h1);
    tick();
    chk("coll_irq", 32'(irq), 32'h1);
    in_port = 4'hF;
    tick(LAT + 2);
    bus_wr(ADDR_EDGE, 32'h1);
    chk("coll_cleared", 32'(dut.edge_capture_q), 32'h0);

    // Masked-off capture, then enable mask
    bus_wr(ADDR_MASK, 32'h0);
    in_port = 4'hB;
    tick(LAT + 1);
    chk("m0_edge", 32'(dut.edge_capture_q), 32'h4);
    chk("m0_irq", 32'(irq), 32'h0);
    bus_wr(ADDR_MASK, 32'h4);
    chk("m4_irq_lag", 32'(irq), 32'h0);
    tick();
    chk("m4_irq_set", 32'(irq), 32'h1);
    bus_rd(ADDR_DATA, rd);
    chk("m4_data", rd, 32'h0000_000B);
    in_port = 4'hF;
    tick(LAT + 2);
    bus_rd(ADDR_MASK, rd);
    chk("rd_mask", rd, 32'h4);
    bus_rd(ADDR_RSVD, rd);
    chk("rd_rsvd", rd, 32'h0);

    // Reset mid-debounce with capture pending
    in_port = 4'h7;
    tick(4);
    reset = 1'b1;
    in_port = 4'hF;
    tick();
    chk("rst2_edge", 32'(dut.edge_capture_q), 32'h0);
    chk("rst2_irq", 32'(irq), 32'h0);
    chk("rst2_mask", 32'(dut.irq_mask_q), 32'h0);
    chk("rst2_readdata", readdata, 32'h0);
    tick(3);
    reset = 1'b0;
    tick(LAT + 6);
    chk("rel_edge", 32'(dut.edge_capture_q), 32'h0);
    chk("rel_irq", 32'(irq), 32'h0);
    bus_rd(ADDR_DATA, rd);
    chk("rel_data", rd, 32'h0000_000F);
    bus_rd(ADDR_MASK, rd);
    chk("rel_mask", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/key_irq_pio.md
Name: key_irq_pio

Overview:
- Parametrised N-channel interrupt-capable parallel input port for pushbuttons and switches.
- Per channel: 2-flop synchroniser, optional debounce, configurable edge detection, edge-capture register, per-bit IRQ mask.
- Avalon-MM slave register interface; single level IRQ output to the processor.
- Successor to the fixed 4-bit KEY PIO in the interrupt labs: channel count, edge polarity, debounce time and idle level are all parameters.

Parameters:
- WIDTH, 4, number of input channels (1..32).
- EDGE_MODE, 1, 0 = rising, 1 = falling, 2 = any edge.
- DB_CYCLES, 500000, debounce stability time in clk cycles (10 ms at 50 MHz); minimum 2.
- IDLE_LEVEL, 1, reset/idle value loaded into every channel's synchroniser and stable state (1 suits active-low KEY).

Ports:
- clk, input, 1, system clock (50 MHz).
- reset, input, 1, synchronous active-high reset.
- in_port, input, WIDTH, asynchronous raw inputs.
- address, input, 2, word address.
- read, input, 1, read strobe.
- write, input, 1, write strobe.
- writedata, input, 32, write data.
- readdata, output, 32, registered read data.
- irq, output, 1, level interrupt request.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - readdata = 0, irq = 0, irq_mask = 0, edge_capture = 0.
  - Synchroniser flops, stable state and stable_d = IDLE_LEVEL replicated; this gives no spurious edge at reset release.
  - Debounce counters = 0.
- Synchroniser: two flops per bit, giving sync[i].
- Debounce, per channel:
  - If sync == stable, the counter clears.
  - Otherwise the counter increments; when it reaches DB_CYCLES-1, stable <= sync and the counter clears.
  - A bounce shorter than DB_CYCLES resets the count.
  - Counter width is $clog2(DB_CYCLES).
- Edge detect: stable_d <= stable each cycle.
  - rise = stable & ~stable_d.
  - fall = ~stable & stable_d.
  - The selected edge per EDGE_MODE sets edge_capture[i].
  - Total latency from in_port change to edge_capture set = 2 + DB_CYCLES + 1 cycles.
- Register map (address, read / write):
  - 0: data = stable (zero-extended) / writes ignored.
  - 1: reserved, reads 0 / writes ignored.
  - 2: irq_mask / irq_mask <= writedata[WIDTH-1:0].
  - 3: edge_capture / write-1-to-clear per bit.
- Read latency: 1 cycle; readdata updates on the cycle after read is high and holds otherwise.
- Clear/set collision: a clear and a new edge on the same bit in the same cycle leaves the bit set (set wins).
- Simultaneous read and write: a read of address 3 coincident with a clear returns the pre-clear value.
- IRQ: irq <= |(edge_capture & irq_mask), registered.
  - Asserts 1 cycle after the capture bit sets or a mask write enables a pending bit.
  - Deasserts 1 cycle after the clearing write.
- Unused readdata bits [31:WIDTH] always read 0.
- Reset mid-debounce discards the partial count; reset with an edge pending clears the capture and irq on the next edge of clk.

Optional Feature:
- Macro: KEY_IRQ_PIO_DEBOUNCE_EN.
- Defined: debounce as above.
- Undefined:
  - No counters are built and stable <= sync directly.
  - Edge latency is 3 cycles.
  - DB_CYCLES is ignored.
  - Every glitch surviving the synchroniser is captured.

Decomposition:
- Package key_irq_pio_pkg:
  - Address localparams ADDR_DATA = 0, ADDR_RSVD = 1, ADDR_MASK = 2, ADDR_EDGE = 3.
  - Edge-mode enum EDGE_RISE / EDGE_FALL / EDGE_ANY.
- Sub-module pio_debounce: one channel containing synchroniser, counter and stable output; parameters DB_CYCLES, IDLE_LEVEL. Instantiated WIDTH times via generate.
- Edge logic, registers and bus decode stay in the top.

Test Plan:
- Bench configuration: WIDTH = 4, DB_CYCLES = 4, EDGE_MODE = 1, debounce enabled.
- Reset with in_port = 4'hF, hold 20 cycles -> edge_capture = 0, irq = 0, read addr 0 returns 32'h0000000F.
- Write addr 2 = 4'h1, drive in_port[0] low for 10 cycles -> edge_capture = 4'h1 at cycle 2+4+1, irq high one cycle later; read addr 3 returns 32'h1.
- in_port[1] pulses low for 3 cycles (< DB_CYCLES) -> no capture, data reads 4'hF throughout.
- Bit 0 pending; write addr 3 = 4'h1 -> capture clears, irq low next cycle. Repeat with a new bit-0 edge landing on the same cycle as the clear -> bit stays 1.
- in_port[2] falls with mask = 0 -> edge_capture = 4'h4, irq = 0. Then write mask = 4'h4 -> irq rises 1 cycle later.
- Assert reset mid-debounce (count 2) and while a capture is pending -> all registers return to reset values, and no edge is produced after release.
